// File: rtl/inv_aes_round_ctrl.sv
// Round sequencer for the iterative inverse AES-128 datapath: walks the initial
// AddRoundKey and ten inverse rounds, addressing the round-key store.
module inv_aes_round_ctrl #(
    parameter int NR = 10,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_ready,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [KW-1:0] key_addr,
    output logic          dp_load,
    output logic          dp_round_en,
    output logic          dp_last,
    output logic          busy,
    output logic [KW-1:0] round
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SUB  = 3'd2,
        ARK  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [KW-1:0] NR_K   = KW'(NR);
    localparam logic [KW-1:0] ONE_K  = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0] ZERO_K = {KW{1'b0}};

    state_t        state_r;
    state_t        state_s;
    logic [KW-1:0] round_r;
    logic [KW-1:0] round_s;

    logic          in_ready_r;
    logic          in_ready_s;
    logic          out_valid_r;
    logic          out_valid_s;
    logic          dp_load_r;
    logic          dp_load_s;
    logic          dp_round_en_r;
    logic          dp_round_en_s;
    logic          dp_last_r;
    logic          dp_last_s;
    logic          busy_r;
    logic          busy_s;
    logic [KW-1:0] key_addr_r;
    logic [KW-1:0] key_addr_s;

    // Next state and round counter; the counter stops at 0 instead of wrapping.
    always_comb begin
        state_s = IDLE;
        round_s = round_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_s = LOAD;
                    round_s = NR_K;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s = SUB;
                round_s = NR_K - ONE_K;
            end
            SUB: begin
                state_s = ARK;
            end
            ARK: begin
                if (round_r == ZERO_K) begin
                    state_s = DONE;
                end else begin
                    state_s = SUB;
                    round_s = round_r - ONE_K;
                end
            end
            DONE: begin
                // out_valid_r is high exactly in DONE, so out_ready alone completes the handshake
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                round_s = ZERO_K;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop aligned with its state.
    always_comb begin
        in_ready_s    = 1'b0;
        out_valid_s   = 1'b0;
        dp_load_s     = 1'b0;
        dp_round_en_s = 1'b0;
        dp_last_s     = 1'b0;
        busy_s        = 1'b0;
        key_addr_s    = ZERO_K;
        case (state_s)
            IDLE: begin
                in_ready_s = key_ready;
            end
            LOAD: begin
                dp_load_s  = 1'b1;
                key_addr_s = NR_K;
                busy_s     = 1'b1;
            end
            SUB: begin
                key_addr_s = round_s;
                busy_s     = 1'b1;
            end
            ARK: begin
                dp_round_en_s = 1'b1;
                dp_last_s     = (round_s == ZERO_K);
                key_addr_s    = round_s;
                busy_s        = 1'b1;
            end
            DONE: begin
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    // State, round counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            round_r       <= ZERO_K;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            dp_load_r     <= 1'b0;
            dp_round_en_r <= 1'b0;
            dp_last_r     <= 1'b0;
            busy_r        <= 1'b0;
            key_addr_r    <= ZERO_K;
        end else begin
            state_r       <= state_s;
            round_r       <= round_s;
            in_ready_r    <= in_ready_s;
            out_valid_r   <= out_valid_s;
            dp_load_r     <= dp_load_s;
            dp_round_en_r <= dp_round_en_s;
            dp_last_r     <= dp_last_s;
            busy_r        <= busy_s;
            key_addr_r    <= key_addr_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign dp_load     = dp_load_r;
    assign dp_round_en = dp_round_en_r;
    assign dp_last     = dp_last_r;
    assign busy        = busy_r;
    assign key_addr    = key_addr_r;
    assign round       = round_r;

endmodule

// File: tb/tb_inv_aes_round_ctrl.sv
// Bench for inv_aes_round_ctrl: a behavioural inverse-AES datapath and key store are
// attached, and a scoreboard checks control timing and recovered plaintext.
module tb_inv_aes_round_ctrl;
    localparam int NR = 10;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_ready;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [KW-1:0] key_addr;
    logic          dp_load;
    logic          dp_round_en;
    logic          dp_last;
    logic          busy;
    logic [KW-1:0] round;

    logic [127:0]  dp_din;
    logic [127:0]  dp_state;
    logic [127:0]  sub_r;

    int unsigned   cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    typedef struct packed {
        logic [127:0] pt;
        int unsigned  t;
    } item_t;
    item_t sb[$];

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];

    inv_aes_round_ctrl #(.NR(NR), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .key_ready(key_ready),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .key_addr(key_addr), .dp_load(dp_load), .dp_round_en(dp_round_en),
        .dp_last(dp_last), .busy(busy), .round(round)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_to(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: actual timeout required event (t=%0t)", nm, $time);
    endtask

    // ---------------- GF(2^8) / AES helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] bget(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = bget(s, 4*((c-r+4)%4)+r);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox[bget(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = bget(s, 4*c); a1 = bget(s, 4*c+1); a2 = bget(s, 4*c+2); a3 = bget(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            o[127-8*(4*c+1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            o[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            o[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
        return o;
    endfunction

    // Whole-block inverse cipher, straight from the algorithm's round order.
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[NR];
        for (int r = NR - 1; r >= 0; r--) begin
            s = inv_sub(inv_shift(s)) ^ rk[r];
            if (r != 0) s = inv_mix(s);
        end
        return s;
    endfunction

    task automatic build_tables();
        logic [7:0] v;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            v = 8'(x);
            inv = 8'h00;
            if (v != 8'h00) begin
                inv = 8'h01;
                for (int i = 0; i < 254; i++) inv = gmul(inv, v);
            end
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h000000};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Round datapath: InvShiftRows/InvSubBytes register every cycle, state written on load/round.
    always @(posedge clk) begin
        sub_r <= inv_sub(inv_shift(dp_state));
        if (dp_load)
            dp_state <= dp_din ^ rk[key_addr];
        else if (dp_round_en)
            dp_state <= dp_last ? (sub_r ^ rk[key_addr]) : inv_mix(sub_r ^ rk[key_addr]);
    end

    // Monitor: k counts cycles after the accept edge (k=0 is the LOAD cycle, k=21 first DONE cycle).
    int mk;
    int mka;
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && cyc >= sb[0].t) begin
                mk  = int'(cyc - sb[0].t);
                mka = (mk == 0) ? NR : ((mk <= 20) ? (NR - 1 - (mk - 1) / 2) : 0);
                chk("dp_load", dp_load, mk == 0);
                chk("dp_round_en", dp_round_en, mk >= 2 && mk <= 20 && mk % 2 == 0);
                chk("dp_last", dp_last, mk == 20);
                chk("out_valid", out_valid, mk >= 21);
                chk("busy", busy, 1'b1);
                chk("in_ready_busy", in_ready, 1'b0);
                if (mk <= 20) begin
                    chk("key_addr", key_addr, mka);
                    chk("round", round, mka);
                end else begin
                    chk("round_done", round, 0);
                end
                if (out_valid) chk("plaintext", dp_state, sb[0].pt);
                if (out_valid && out_ready) sb.pop_front();
            end else begin
                chk("idle_busy", busy, 1'b0);
                chk("idle_out_valid", out_valid, 1'b0);
                chk("idle_dp_load", dp_load, 1'b0);
                chk("idle_dp_round_en", dp_round_en, 1'b0);
            end
        end
    end

    // Driver: present one block, push its expectation on the accepting edge.
    task automatic send(input logic [127:0] ct, input logic [127:0] exp, input bit hold,
                        output int unsigned t_acc);
        bit    got;
        item_t it;
        got = 1'b0;
        t_acc = 0;
        dp_din = ct;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                t_acc = cyc + 1;
                it.pt = exp;
                it.t = t_acc;
                sb.push_back(it);
            end
        end
        if (!got) begin
            fail_to("accept");
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            if (!hold) in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            fail_to("drain");
            sb.delete();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_dp_load"}, dp_load, 1'b0);
        chk({tag, "_dp_round_en"}, dp_round_en, 1'b0);
        chk({tag, "_dp_last"}, dp_last, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_key_addr"}, key_addr, 0);
        chk({tag, "_round"}, round, 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t;
        int unsigned prev;
        int unsigned c;
        bit          rand_done;
        logic [127:0] ct;

        rst_n = 1'b0; key_ready = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dp_din = 128'h0;
        build_tables();
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        #1;
        chk("in_ready_at_release", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("in_ready_after_release", in_ready, 1'b1);

        // Known-answer block
        send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1'b0, t);
        drain();

        // Random blocks with random downstream backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ct = rnd128();
                    send(ct, ref_decrypt(ct), 1'b0, t);
                    drain();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Held backpressure in DONE
        out_ready = 1'b0;
        ct = rnd128();
        send(ct, ref_decrypt(ct), 1'b0, t);
        for (int i = 0; i < 60 && !out_valid; i++) begin @(posedge clk); #1; end
        if (!out_valid) fail_to("bp_out_valid");
        repeat (15) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_out_valid_after", out_valid, 1'b0);
        chk("bp_in_ready_after", in_ready, 1'b1);

        // key_ready low gates accepts
        key_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ct = rnd128();
        dp_din = ct;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("kr_in_ready", in_ready, 1'b0);
            chk("kr_busy", busy, 1'b0);
            chk("kr_dp_load", dp_load, 1'b0);
        end
        key_ready = 1'b1;
        c = cyc;
        send(ct, ref_decrypt(ct), 1'b0, t);
        chk("kr_accept_edge", t, c + 2);
        drain();

        // Asynchronous reset during ARK of round 4, then a fresh block
        ct = rnd128();
        send(ct, ref_decrypt(ct), 1'b0, t);
        for (int i = 0; i < 40 && !(dp_round_en && key_addr == 4'd4); i++) begin @(posedge clk); #1; end
        if (!(dp_round_en && key_addr == 4'd4)) fail_to("reach_ark4");
        chk("ark4_round", round, 4);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_reset("midreset");
        @(posedge clk); #1;
        chk_reset("midreset_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_midreset", in_ready, 1'b1);
        ct = rnd128();
        send(ct, ref_decrypt(ct), 1'b0, t);
        drain();

        // Back-to-back with in_valid held through busy
        prev = 0;
        for (int b = 0; b < 4; b++) begin
            ct = rnd128();
            send(ct, ref_decrypt(ct), 1'b1, t);
            if (b > 0) chk("b2b_spacing", t - prev, 23);
            prev = t;
        end
        in_valid = 1'b0;
        drain();
        repeat (3) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
